// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, one-hot
// C-type funcs, ALU operation codes and error codes.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF   = 5'd0,
    S_ID   = 5'd1,
    S_LWA  = 5'd2,
    S_LWB  = 5'd3,
    S_SW   = 5'd4,
    S_JMP  = 5'd5,
    S_BRZ  = 5'd6,
    S_MT   = 5'd7,
    S_MF0  = 5'd8,
    S_MF1  = 5'd9,
    S_R1   = 5'd10,
    S_R2   = 5'd11,
    S_R3   = 5'd12,
    S_IMM  = 5'd13,
    S_IWB  = 5'd14,
    S_HALT = 5'd15,
    S_ERR  = 5'd16
  } state_t;

  localparam logic [3:0] OP_LW    = 4'b0000;
  localparam logic [3:0] OP_SW    = 4'b0001;
  localparam logic [3:0] OP_J     = 4'b0010;
  localparam logic [3:0] OP_HALT  = 4'b0011;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_CTYPE = 4'b1000;

  localparam logic [8:0] F_MT  = 9'h001;
  localparam logic [8:0] F_MF  = 9'h002;
  localparam logic [8:0] F_ADD = 9'h004;
  localparam logic [8:0] F_SUB = 9'h008;
  localparam logic [8:0] F_AND = 9'h010;
  localparam logic [8:0] F_OR  = 9'h020;
  localparam logic [8:0] F_XOR = 9'h040;
  localparam logic [8:0] F_NOP = 9'h080;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // Selects where alu_op_decode takes the operation from.
  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_SUB = 2'd1,
    CLS_R   = 2'd2,
    CLS_IMM = 2'd3
  } alu_cls_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_rtype_func(input logic [8:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_XOR);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation select: fixed add/sub, R-type func, or immediate
// opcode[1:0].
module alu_op_decode
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  alu_cls_t           cls,
  input  logic [8:0]         func,
  input  logic [1:0]         imm_sel,
  output logic [ALUOP_W-1:0] alu_op
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (cls)
      CLS_ADD: code = ALU_ADD;
      CLS_SUB: code = ALU_SUB;
      CLS_R: begin
        case (func)
          F_SUB:   code = ALU_SUB;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          F_XOR:   code = ALU_XOR;
          default: code = ALU_ADD;
        endcase
      end
      CLS_IMM: begin
        case (imm_sel)
          2'b00:   code = ALU_ADD;
          2'b01:   code = ALU_SUB;
          2'b10:   code = ALU_AND;
          default: code = ALU_OR;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_op = ALUOP_W'(code);

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle controller for the 16-bit accumulator/stack datapath with memory
// ready handshake, watchdog timeout, illegal-instruction trap and HALT/resume.
//
// state | meaning
// IF    | fetch, wait for mem_ready, PC+1
// ID    | decode and dispatch
// LWA   | data read, wait for mem_ready
// LWB   | write loaded word to stack/acc
// SW    | data write, wait for mem_ready
// JMP   | jump
// BRZ   | branch if zero
// MT    | move to register
// MF0   | move from, first half
// MF1   | move from, write back
// R1    | R-type operand read
// R2    | R-type ALU operation
// R3    | R-type write back
// IMM   | immediate ALU operation
// IWB   | immediate write back
// HALT  | stopped until resume
// ERR   | trapped, only rst_n exits
module multicycle_ctrl_hs
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int ALUOP_W = 3,
  parameter int TMO_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  input  logic               resume,
  output logic               mem_req,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               DM,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               IRWrite,
  output logic               ARS,
  output logic               RegWrite,
  output logic               IMS,
  output logic               NI,
  output logic [1:0]         PCSrc,
  output logic [1:0]         MemToReg,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               halted,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [4:0]         state
);

  // Last count before expiry: the (2**TMO_W-1)-th consecutive wait cycle traps.
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           ps, ns;
  logic [TMO_W-1:0] wd_cnt, wd_nxt;
  logic [1:0]       err_code_q, err_code_nxt;
  logic             wait_cycle, wd_expire;
  logic [3:0]       opcode;
  logic [8:0]       func;
  alu_cls_t         alu_cls;
  logic             mem_req_c, pc_write_c, pc_write_cond_c, mem_write_c, ir_write_c, reg_write_c;
  logic             unused_instr;

  assign opcode       = instruction[INSTR_W-1 -: 4];
  assign func         = instruction[8:0];
  assign unused_instr = ^instruction;

  assign wait_cycle = ((ps == S_IF) || (ps == S_LWA) || (ps == S_SW)) && !mem_ready;
  assign wd_expire  = wait_cycle && (wd_cnt == WD_LAST);
  assign wd_nxt     = wait_cycle ? wd_cnt + TMO_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps         <= S_IF;
      wd_cnt     <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      ps         <= ns;
      wd_cnt     <= wd_nxt;
      err_code_q <= err_code_nxt;
    end
  end

  always_comb begin
    ns              = ps;
    err_code_nxt    = err_code_q;
    alu_cls         = CLS_ADD;
    mem_req_c       = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    DM              = 1'b0;
    MemRead         = 1'b0;
    ARS             = 1'b0;
    IMS             = 1'b0;
    NI              = 1'b0;
    PCSrc           = 2'b00;
    MemToReg        = 2'b00;
    halted          = 1'b0;
    err             = 1'b0;
    case (ps)
      S_IF: begin
        mem_req_c = 1'b1;
        MemRead   = 1'b1;
        NI        = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          ns         = S_ID;
        end else if (wd_expire) begin
          ns           = S_ERR;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      S_ID: begin
        ARS = 1'b1;
        if (opcode[3:2] == 2'b11) begin
          ns = S_IMM;
        end else begin
          case (opcode)
            OP_LW:   ns = S_LWA;
            OP_SW:   ns = S_SW;
            OP_J:    ns = S_JMP;
            OP_BRZ:  ns = S_BRZ;
            OP_HALT: ns = S_HALT;
            OP_CTYPE: begin
              if (func == F_MT) begin
                ns = S_MT;
              end else if (func == F_MF) begin
                ns = S_MF0;
              end else if (is_rtype_func(func)) begin
                ns = S_R1;
              end else if (func == F_NOP) begin
                ns = S_IF;
              end else begin
                ns           = S_ERR;
                err_code_nxt = ERR_ILLEGAL;
              end
            end
            default: begin
              ns           = S_ERR;
              err_code_nxt = ERR_ILLEGAL;
            end
          endcase
        end
      end
      S_LWA: begin
        DM        = 1'b1;
        MemRead   = 1'b1;
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ns = S_LWB;
        end else if (wd_expire) begin
          ns           = S_ERR;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      S_LWB: begin
        ARS         = 1'b1;
        MemToReg    = 2'b01;
        reg_write_c = 1'b1;
        ns          = S_IF;
      end
      S_SW: begin
        DM        = 1'b1;
        ARS       = 1'b1;
        mem_req_c = 1'b1;
        if (mem_ready) begin
          mem_write_c = 1'b1;
          ns          = S_IF;
        end else if (wd_expire) begin
          ns           = S_ERR;
          err_code_nxt = ERR_TIMEOUT;
        end
      end
      S_JMP: begin
        PCSrc      = 2'b01;
        pc_write_c = 1'b1;
        ns         = S_IF;
      end
      S_BRZ: begin
        ARS             = 1'b1;
        PCSrc           = 2'b10;
        alu_cls         = CLS_SUB;
        pc_write_cond_c = 1'b1;
        ns              = S_IF;
      end
      S_MT: begin
        reg_write_c = 1'b1;
        ns          = S_IF;
      end
      S_MF0: ns = S_MF1;
      S_MF1: begin
        ARS         = 1'b1;
        reg_write_c = 1'b1;
        ns          = S_IF;
      end
      S_R1: begin
        ARS = 1'b1;
        ns  = S_R2;
      end
      S_R2: begin
        alu_cls = CLS_R;
        ns      = S_R3;
      end
      S_R3, S_IWB: begin
        ARS         = 1'b1;
        MemToReg    = 2'b10;
        reg_write_c = 1'b1;
        ns          = S_IF;
      end
      S_IMM: begin
        IMS     = 1'b1;
        alu_cls = CLS_IMM;
        ns      = S_IWB;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) ns = S_IF;
      end
      S_ERR: err = 1'b1;
      default: ns = S_ERR;
    endcase
  end

  alu_op_decode #(.ALUOP_W(ALUOP_W)) u_alu_op_decode (
    .cls     (alu_cls),
    .func    (func),
    .imm_sel (opcode[1:0]),
    .alu_op  (ALUop)
  );

  // Write strobes and mem_req drop combinationally the moment rst_n falls.
  assign mem_req     = mem_req_c & rst_n;
  assign PCWrite     = pc_write_c & rst_n;
  assign PCWriteCond = pc_write_cond_c & rst_n;
  assign MemWrite    = mem_write_c & rst_n;
  assign IRWrite     = ir_write_c & rst_n;
  assign RegWrite    = reg_write_c & rst_n;
  assign IorD        = 1'b0;
  assign err_code    = err_code_q;
  assign state       = ps;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Self-checking bench for multicycle_ctrl_hs: scripted scenarios plus random
// instruction streams checked against a per-instruction path model.
module tb_multicycle_ctrl_hs;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        mem_ready = 1'b0;
  logic        resume = 1'b0;

  logic mem_req, PCWrite, PCWriteCond, IorD, DM, MemWrite, MemRead, IRWrite, ARS, RegWrite, IMS, NI;
  logic [1:0] PCSrc, MemToReg, err_code;
  logic [2:0] ALUop;
  logic halted, err;
  logic [4:0] state;

  logic t_mem_req, t_PCWrite, t_PCWriteCond, t_IorD, t_DM, t_MemWrite, t_MemRead, t_IRWrite;
  logic t_ARS, t_RegWrite, t_IMS, t_NI, t_halted, t_err;
  logic [1:0] t_PCSrc, t_MemToReg, t_err_code;
  logic [2:0] t_ALUop;
  logic [4:0] t_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] st;
    bit         rdy;
  } step_t;
  step_t seq[$];

  multicycle_ctrl_hs #(.INSTR_W(16), .ALUOP_W(3), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready), .resume(resume),
    .mem_req(mem_req), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .DM(DM),
    .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite), .ARS(ARS), .RegWrite(RegWrite),
    .IMS(IMS), .NI(NI), .PCSrc(PCSrc), .MemToReg(MemToReg), .ALUop(ALUop), .halted(halted),
    .err(err), .err_code(err_code), .state(state)
  );

  multicycle_ctrl_hs #(.INSTR_W(16), .ALUOP_W(3), .TMO_W(2)) dut_t (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready), .resume(resume),
    .mem_req(t_mem_req), .PCWrite(t_PCWrite), .PCWriteCond(t_PCWriteCond), .IorD(t_IorD), .DM(t_DM),
    .MemWrite(t_MemWrite), .MemRead(t_MemRead), .IRWrite(t_IRWrite), .ARS(t_ARS), .RegWrite(t_RegWrite),
    .IMS(t_IMS), .NI(t_NI), .PCSrc(t_PCSrc), .MemToReg(t_MemToReg), .ALUop(t_ALUop), .halted(t_halted),
    .err(t_err), .err_code(t_err_code), .state(t_state)
  );

  always #5 clk = ~clk;

  function automatic void push(input logic [4:0] s, input bit r);
    step_t e;
    e.st = s;
    e.rdy = r;
    seq.push_back(e);
  endfunction

  function automatic void push_mem(input logic [4:0] s, input int waits);
    for (int i = 0; i < waits; i++) push(s, 1'b0);
    push(s, 1'b1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    resume = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    instruction = 16'h8004;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 5'(S_IF)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, S_IF); end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++;
    if ({PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite} !== 5'b0) begin
      errors++; $display("FAIL reset_enables got=%b exp=00000", {PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite});
    end
    checks++;
    if ({err, halted, err_code} !== 4'b0) begin
      errors++; $display("FAIL reset_err got=%b%b%b exp=0000", err, halted, err_code);
    end
  endtask

  task automatic test_add();
    logic [4:0] exp_st [6];
    exp_st = '{S_IF, S_ID, S_R1, S_R2, S_R3, S_IF};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 16'h8004;
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state !== exp_st[i]) begin errors++; $display("FAIL add_state step=%0d got=%0d exp=%0d", i, state, exp_st[i]); end
      checks++;
      if (RegWrite !== (i == 4)) begin errors++; $display("FAIL add_regwrite step=%0d got=%b exp=%b", i, RegWrite, i == 4); end
      if (i == 3) begin
        checks++;
        if (ALUop !== ALU_ADD) begin errors++; $display("FAIL add_aluop got=%0d exp=%0d", ALUop, ALU_ADD); end
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [4:0] exp_st [8];
    bit         rdy [8];
    exp_st = '{S_IF, S_ID, S_LWA, S_LWA, S_LWA, S_LWA, S_LWB, S_IF};
    rdy = '{1, 1, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 16'h0abc;
      mem_ready = rdy[i];
      #1;
      checks++;
      if (state !== exp_st[i] || err !== 1'b0) begin
        errors++; $display("FAIL lw_state step=%0d got=%0d/err%b exp=%0d/err0", i, state, err, exp_st[i]);
      end
      checks++;
      if (RegWrite !== (i == 6)) begin errors++; $display("FAIL lw_regwrite step=%0d got=%b exp=%b", i, RegWrite, i == 6); end
      if (i == 6) begin
        checks++;
        if (MemToReg !== 2'b01) begin errors++; $display("FAIL lw_memtoreg got=%b exp=01", MemToReg); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [15:0] ills [2];
    ills = '{16'h5000, 16'h8003};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      @(negedge clk); instruction = ills[k]; mem_ready = 1'b1; #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      checks++;
      if (state !== 5'(S_ERR) || err !== 1'b1 || err_code !== ERR_ILLEGAL) begin
        errors++; $display("FAIL illegal_trap ins=%h got=%0d/%b/%b exp=%0d/1/01", ills[k], state, err, err_code, S_ERR);
      end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++;
        if (state !== 5'(S_ERR) || {mem_req, PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite} !== 6'b0) begin
          errors++; $display("FAIL illegal_absorb got=%0d en=%b exp=%0d en=000000", state,
                             {mem_req, PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite}, S_ERR);
        end
      end
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) instruction = 16'h8080;
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state !== ((i == 1) ? 5'(S_ID) : 5'(S_IF)) || RegWrite !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL nop_path step=%0d got=%0d rw=%b err=%b", i, state, RegWrite, err);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    @(negedge clk); instruction = 16'h3000; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    checks++;
    if (state !== 5'(S_ID)) begin errors++; $display("FAIL halt_decode got=%0d exp=%0d", state, S_ID); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); mem_ready = 1'($urandom); #1;
      checks++;
      if (state !== 5'(S_HALT) || halted !== 1'b1 ||
          {mem_req, PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite} !== 6'b0) begin
        errors++; $display("FAIL halt_hold cyc=%0d got=%0d halted=%b exp=%0d halted=1", i, state, halted, S_HALT);
      end
    end
    @(negedge clk); resume = 1'b1; #1;
    checks++;
    if (state !== 5'(S_HALT)) begin errors++; $display("FAIL halt_resume_cycle got=%0d exp=%0d", state, S_HALT); end
    @(negedge clk); resume = 1'b0; mem_ready = 1'b1; instruction = 16'h8080; #1;
    checks++;
    if (state !== 5'(S_IF) || halted !== 1'b0 || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      errors++; $display("FAIL halt_refetch got=%0d halted=%b irw=%b pcw=%b exp=%0d 0 1 1", state, halted, IRWrite, PCWrite, S_IF);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 5'(S_ID)) begin errors++; $display("FAIL halt_after got=%0d exp=%0d", state, S_ID); end
  endtask

  task automatic test_timeout();
    // Small watchdog: ready on the third cycle still completes.
    do_reset();
    instruction = 16'h8080;
    @(negedge clk); #1;
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    checks++;
    if (t_state !== 5'(S_ID) || t_err !== 1'b0) begin
      errors++; $display("FAIL tmo_boundary got=%0d err=%b exp=%0d err=0", t_state, t_err, S_ID);
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (t_state !== 5'(S_IF)) begin errors++; $display("FAIL tmo_wait cyc=%0d got=%0d exp=%0d", i, t_state, S_IF); end
    end
    @(negedge clk); #1;
    checks++;
    if (t_state !== 5'(S_ERR) || t_err !== 1'b1 || t_err_code !== ERR_TIMEOUT) begin
      errors++; $display("FAIL tmo_trap got=%0d/%b/%b exp=%0d/1/10", t_state, t_err, t_err_code, S_ERR);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      checks++;
      if (t_state !== 5'(S_ERR) || {t_mem_req, t_PCWrite, t_PCWriteCond, t_MemWrite, t_IRWrite, t_RegWrite} !== 6'b0) begin
        errors++; $display("FAIL tmo_absorb got=%0d en=%b", t_state,
                           {t_mem_req, t_PCWrite, t_PCWriteCond, t_MemWrite, t_IRWrite, t_RegWrite});
      end
    end
    rst_n = 1'b0; #1;
    checks++;
    if (t_err_code !== ERR_NONE || t_err !== 1'b0 || t_state !== 5'(S_IF)) begin
      errors++; $display("FAIL tmo_clear got=%0d/%b/%b exp=%0d/0/00", t_state, t_err, t_err_code, S_IF);
    end
    // Full-size watchdog: 14 waits then ready completes, 15 waits trap.
    do_reset();
    seq.delete();
    push(S_IF, 1); push(S_ID, 1); push_mem(S_LWA, 14); push(S_LWB, 1);
    push(S_IF, 1); push(S_ID, 1);
    for (int i = 0; i < 15; i++) push(S_SW, 0);
    push(S_ERR, 1);
    foreach (seq[i]) begin
      @(negedge clk);
      if (i == 0) instruction = 16'h0000;
      if (i == 18) instruction = 16'h1000;
      mem_ready = seq[i].rdy;
      #1;
      checks++;
      if (state !== seq[i].st) begin errors++; $display("FAIL wd_path step=%0d got=%0d exp=%0d", i, state, seq[i].st); end
    end
    checks++;
    if (err_code !== ERR_TIMEOUT || err !== 1'b1 || MemWrite !== 1'b0) begin
      errors++; $display("FAIL wd_code got=%b err=%b mw=%b exp=10 1 0", err_code, err, MemWrite);
    end
  endtask

  task automatic test_reset_mid_sw();
    do_reset();
    @(negedge clk); instruction = 16'h1234; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++;
    if (state !== 5'(S_SW) || mem_req !== 1'b1) begin
      errors++; $display("FAIL sw_pre got=%0d req=%b exp=%0d req=1", state, mem_req, S_SW);
    end
    rst_n = 1'b0; mem_ready = 1'b1; #1;
    checks++;
    if ({mem_req, MemWrite, IRWrite, PCWrite} !== 4'b0 || state !== 5'(S_IF)) begin
      errors++; $display("FAIL sw_rst_drop got=%b st=%0d exp=0000 st=%0d", {mem_req, MemWrite, IRWrite, PCWrite}, state, S_IF);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (state !== 5'(S_IF) || err !== 1'b0 || err_code !== ERR_NONE || mem_req !== 1'b1) begin
      errors++; $display("FAIL sw_rst_release got=%0d err=%b code=%b req=%b", state, err, err_code, mem_req);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [8:0]  f;
    logic [1:0]  sel;
    logic [2:0]  exp_alu;
    logic [8:0]  funcs [8];
    logic        exp_mr;
    int exp_rw, exp_pcw, exp_pcwc, exp_mw;
    int got_rw, got_pcw, got_pcwc, got_mw, got_irw;
    funcs = '{F_MT, F_MF, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOP};
    do_reset();
    for (int n = 0; n < 150; n++) begin
      seq.delete();
      ins = 16'h8080;
      exp_rw = 0; exp_pcw = 1; exp_pcwc = 0; exp_mw = 0; exp_alu = ALU_ADD;
      push_mem(S_IF, $urandom_range(0, 4));
      push(S_ID, 1'($urandom));
      case ($urandom_range(0, 5))
        0: begin ins = {OP_LW, 12'($urandom)}; push_mem(S_LWA, $urandom_range(0, 4)); push(S_LWB, 1'($urandom)); exp_rw = 1; end
        1: begin ins = {OP_SW, 12'($urandom)}; push_mem(S_SW, $urandom_range(0, 4)); exp_mw = 1; end
        2: begin ins = {OP_J, 12'($urandom)}; push(S_JMP, 1'($urandom)); exp_pcw = 2; end
        3: begin ins = {OP_BRZ, 12'($urandom)}; push(S_BRZ, 1'($urandom)); exp_pcwc = 1; end
        4: begin
          f = funcs[$urandom_range(0, 7)];
          ins = {OP_CTYPE, 3'($urandom), f};
          case (f)
            F_MT: begin push(S_MT, 1'($urandom)); exp_rw = 1; end
            F_MF: begin push(S_MF0, 1'($urandom)); push(S_MF1, 1'($urandom)); exp_rw = 1; end
            F_NOP: ;
            default: begin
              push(S_R1, 1'($urandom)); push(S_R2, 1'($urandom)); push(S_R3, 1'($urandom));
              exp_rw = 1;
              case (f)
                F_SUB: exp_alu = ALU_SUB;
                F_AND: exp_alu = ALU_AND;
                F_OR:  exp_alu = ALU_OR;
                F_XOR: exp_alu = ALU_XOR;
                default: exp_alu = ALU_ADD;
              endcase
            end
          endcase
        end
        default: begin
          sel = 2'($urandom);
          ins = {2'b11, sel, 12'($urandom)};
          push(S_IMM, 1'($urandom)); push(S_IWB, 1'($urandom));
          exp_rw = 1;
          exp_alu = (sel == 2'd0) ? ALU_ADD : (sel == 2'd1) ? ALU_SUB : (sel == 2'd2) ? ALU_AND : ALU_OR;
        end
      endcase
      got_rw = 0; got_pcw = 0; got_pcwc = 0; got_mw = 0; got_irw = 0;
      foreach (seq[i]) begin
        @(negedge clk);
        if (i == 0) instruction = ins;
        mem_ready = seq[i].rdy;
        #1;
        checks++;
        if (state !== seq[i].st) begin
          errors++; $display("FAIL rand_state n=%0d step=%0d ins=%h got=%0d exp=%0d", n, i, ins, state, seq[i].st);
        end
        exp_mr = (seq[i].st == 5'(S_IF)) || (seq[i].st == 5'(S_LWA)) || (seq[i].st == 5'(S_SW));
        checks++;
        if (mem_req !== exp_mr) begin
          errors++; $display("FAIL rand_mem_req n=%0d step=%0d got=%b exp=%b", n, i, mem_req, exp_mr);
        end
        if (seq[i].st == 5'(S_R2) || seq[i].st == 5'(S_IMM)) begin
          checks++;
          if (ALUop !== exp_alu) begin errors++; $display("FAIL rand_aluop n=%0d ins=%h got=%0d exp=%0d", n, ins, ALUop, exp_alu); end
        end
        got_rw += int'(RegWrite); got_pcw += int'(PCWrite); got_pcwc += int'(PCWriteCond);
        got_mw += int'(MemWrite); got_irw += int'(IRWrite);
      end
      checks++;
      if (got_rw != exp_rw || got_pcw != exp_pcw || got_pcwc != exp_pcwc || got_mw != exp_mw || got_irw != 1) begin
        errors++;
        $display("FAIL rand_enables n=%0d ins=%h got rw%0d pcw%0d pcwc%0d mw%0d irw%0d exp rw%0d pcw%0d pcwc%0d mw%0d irw1",
                 n, ins, got_rw, got_pcw, got_pcwc, got_mw, got_irw, exp_rw, exp_pcw, exp_pcwc, exp_mw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_illegal();
    test_halt();
    test_timeout();
    test_reset_mid_sw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
